alu_rs: RTL and testbench

//  ALU reservation station: the issuing end of the RS->ALU interface. Buffers decoded ALU/branch/jump
//  ops from dispatch, tracks operand readiness by ROB tag, snoops the ALU and LSB result broadcasts
//  for wakeup, and issues one ready op per cycle to the ALU (rs_en/opcode/funct3/funct7/val1/val2/imm/rob_pos/pc).

---
 rtl/alu_rs_pkg.sv | 66 ++++++
 rtl/alu_rs_if.sv | 17 +
 rtl/alu_rs_pick.sv | 23 ++
 rtl/alu_rs.sv | 119 +++++++++++
 tb/tb_alu_rs.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_pkg.sv
// Shared widths, opcodes and entry layout for the ALU reservation station.
package alu_rs_pkg;

  localparam int DATA_WID = 32;
  localparam int ADDR_WID = 32;
  localparam int ROB_WID  = 4;
  localparam int RS_SIZE  = 16;
  localparam int IDX_W    = 4;

  localparam logic [6:0] OPCODE_CAL   = 7'b0110011;
  localparam logic [6:0] OPCODE_CALI  = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
  localparam logic [6:0] OPCODE_B     = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR  = 7'b1100111;

  typedef struct packed {
    logic                busy;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic                funct7;
    logic                q1_rdy;
    logic [ROB_WID-1:0]  q1_rob;
    logic [DATA_WID-1:0] v1;
    logic                q2_rdy;
    logic [ROB_WID-1:0]  q2_rob;
    logic [DATA_WID-1:0] v2;
    logic [DATA_WID-1:0] imm;
    logic [ROB_WID-1:0]  rob_pos;
    logic [ADDR_WID-1:0] pc;
  } rs_entry_t;

  typedef struct packed {
    logic                rdy;
    logic [DATA_WID-1:0] val;
  } operand_t;

  // A waiting operand picks up a broadcast whose tag matches; ALU wins a tie.
  function automatic operand_t snoop(
    input logic                rdy,
    input logic [ROB_WID-1:0]  tag,
    input logic [DATA_WID-1:0] val,
    input logic                alu_done,
    input logic [ROB_WID-1:0]  alu_rob,
    input logic [DATA_WID-1:0] alu_cal,
    input logic                lsb_done,
    input logic [ROB_WID-1:0]  lsb_rob,
    input logic [DATA_WID-1:0] lsb_val
  );
    operand_t o;
    o.rdy = rdy;
    o.val = val;
    if (!rdy) begin
      if (alu_done && alu_rob == tag) begin
        o.rdy = 1'b1;
        o.val = alu_cal;
      end else if (lsb_done && lsb_rob == tag) begin
        o.rdy = 1'b1;
        o.val = lsb_val;
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Issue bus from the reservation station to the ALU.
interface alu_rs_if;
  import alu_rs_pkg::*;

  logic                en;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                funct7;
  logic [DATA_WID-1:0] val1;
  logic [DATA_WID-1:0] val2;
  logic [DATA_WID-1:0] imm;
  logic [ROB_WID-1:0]  rob_pos;
  logic [ADDR_WID-1:0] pc;

  modport master (output en, opcode, funct3, funct7, val1, val2, imm, rob_pos, pc);
  modport slave  (input  en, opcode, funct3, funct7, val1, val2, imm, rob_pos, pc);
endinterface

// File: rtl/alu_rs_pick.sv
// Lowest-set-bit finder used for both free-slot and ready-slot selection.
module alu_rs_pick #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scanning downward lets the lowest set index be the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, wakes operands from result
// broadcasts and issues the lowest-index ready op to the ALU each cycle.
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                dec_en,
  input  logic [6:0]          dec_opcode,
  input  logic [2:0]          dec_funct3,
  input  logic                dec_funct7,
  input  logic                dec_rs1_rdy,
  input  logic [DATA_WID-1:0] dec_rs1_val,
  input  logic [ROB_WID-1:0]  dec_rs1_rob,
  input  logic                dec_rs2_rdy,
  input  logic [DATA_WID-1:0] dec_rs2_val,
  input  logic [ROB_WID-1:0]  dec_rs2_rob,
  input  logic [DATA_WID-1:0] dec_imm,
  input  logic [ROB_WID-1:0]  dec_rob_pos,
  input  logic [ADDR_WID-1:0] dec_pc,
  output logic                rs_full,
  input  logic                alu_res_done,
  input  logic [ROB_WID-1:0]  alu_res_rob_pos,
  input  logic [DATA_WID-1:0] alu_res_cal,
  input  logic                lsb_res_done,
  input  logic [ROB_WID-1:0]  lsb_res_rob_pos,
  input  logic [DATA_WID-1:0] lsb_res_val,
  alu_rs_if.master            alu
);

  rs_entry_t          ent [RS_SIZE];
  operand_t           wake1 [RS_SIZE];
  operand_t           wake2 [RS_SIZE];
  operand_t           new_op1, new_op2;
  logic [RS_SIZE-1:0] busy_vec, ready_vec;
  logic [IDX_W-1:0]   free_idx, issue_idx;
  logic               free_found, issue_found;

  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ent[i].busy;
      ready_vec[i] = ent[i].busy && ent[i].q1_rdy && ent[i].q2_rdy;
      wake1[i] = snoop(ent[i].q1_rdy, ent[i].q1_rob, ent[i].v1,
                       alu_res_done, alu_res_rob_pos, alu_res_cal,
                       lsb_res_done, lsb_res_rob_pos, lsb_res_val);
      wake2[i] = snoop(ent[i].q2_rdy, ent[i].q2_rob, ent[i].v2,
                       alu_res_done, alu_res_rob_pos, alu_res_cal,
                       lsb_res_done, lsb_res_rob_pos, lsb_res_val);
    end
    new_op1 = snoop(dec_rs1_rdy, dec_rs1_rob, dec_rs1_val,
                    alu_res_done, alu_res_rob_pos, alu_res_cal,
                    lsb_res_done, lsb_res_rob_pos, lsb_res_val);
    new_op2 = snoop(dec_rs2_rdy, dec_rs2_rob, dec_rs2_val,
                    alu_res_done, alu_res_rob_pos, alu_res_cal,
                    lsb_res_done, lsb_res_rob_pos, lsb_res_val);
  end

  assign rs_full = &busy_vec;

  alu_rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_free_pick (
    .vec   (~busy_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  alu_rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_issue_pick (
    .vec   (ready_vec),
    .idx   (issue_idx),
    .found (issue_found)
  );

  // Selection reads pre-edge state, so a broadcast never wakes and issues in one edge.
  always_ff @(posedge clk) begin
    if (!rst_n || rollback) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      alu.en      <= 1'b0;
      alu.opcode  <= '0;
      alu.funct3  <= '0;
      alu.funct7  <= 1'b0;
      alu.val1    <= '0;
      alu.val2    <= '0;
      alu.imm     <= '0;
      alu.rob_pos <= '0;
      alu.pc      <= '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent[i].busy) begin
          ent[i].q1_rdy <= wake1[i].rdy;
          ent[i].v1     <= wake1[i].val;
          ent[i].q2_rdy <= wake2[i].rdy;
          ent[i].v2     <= wake2[i].val;
        end
      end
      alu.en <= issue_found;
      if (issue_found) begin
        alu.opcode          <= ent[issue_idx].opcode;
        alu.funct3          <= ent[issue_idx].funct3;
        alu.funct7          <= ent[issue_idx].funct7;
        alu.val1            <= ent[issue_idx].v1;
        alu.val2            <= ent[issue_idx].v2;
        alu.imm             <= ent[issue_idx].imm;
        alu.rob_pos         <= ent[issue_idx].rob_pos;
        alu.pc              <= ent[issue_idx].pc;
        ent[issue_idx].busy <= 1'b0;
      end
      if (dec_en && free_found) begin
        ent[free_idx] <= '{busy: 1'b1, opcode: dec_opcode, funct3: dec_funct3,
                           funct7: dec_funct7, q1_rdy: new_op1.rdy, q1_rob: dec_rs1_rob,
                           v1: new_op1.val, q2_rdy: new_op2.rdy, q2_rob: dec_rs2_rob,
                           v2: new_op2.val, imm: dec_imm, rob_pos: dec_rob_pos, pc: dec_pc};
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: per-scenario tasks with inline checks, plus an
// issue monitor that compares every issued op against a scoreboard queue.
module tb_alu_rs;

  localparam logic [6:0] OP_CAL  = 7'b0110011;
  localparam logic [6:0] OP_CALI = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] imm;
    logic [3:0]  rob_pos;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, rdy, rollback;
  logic        dec_en, dec_funct7, dec_rs1_rdy, dec_rs2_rdy;
  logic [6:0]  dec_opcode;
  logic [2:0]  dec_funct3;
  logic [31:0] dec_rs1_val, dec_rs2_val, dec_imm, dec_pc;
  logic [3:0]  dec_rs1_rob, dec_rs2_rob, dec_rob_pos;
  logic        rs_full;
  logic        alu_res_done, lsb_res_done;
  logic [3:0]  alu_res_rob_pos, lsb_res_rob_pos;
  logic [31:0] alu_res_cal, lsb_res_val;

  int   errors = 0;
  int   checks = 0;
  logic rdy_q  = 1'b0;
  exp_t sb[$];
  exp_t mon_exp;

  alu_rs_if alu_bus();

  alu_rs dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rdy             (rdy),
    .rollback        (rollback),
    .dec_en          (dec_en),
    .dec_opcode      (dec_opcode),
    .dec_funct3      (dec_funct3),
    .dec_funct7      (dec_funct7),
    .dec_rs1_rdy     (dec_rs1_rdy),
    .dec_rs1_val     (dec_rs1_val),
    .dec_rs1_rob     (dec_rs1_rob),
    .dec_rs2_rdy     (dec_rs2_rdy),
    .dec_rs2_val     (dec_rs2_val),
    .dec_rs2_rob     (dec_rs2_rob),
    .dec_imm         (dec_imm),
    .dec_rob_pos     (dec_rob_pos),
    .dec_pc          (dec_pc),
    .rs_full         (rs_full),
    .alu_res_done    (alu_res_done),
    .alu_res_rob_pos (alu_res_rob_pos),
    .alu_res_cal     (alu_res_cal),
    .lsb_res_done    (lsb_res_done),
    .lsb_res_rob_pos (lsb_res_rob_pos),
    .lsb_res_val     (lsb_res_val),
    .alu             (alu_bus)
  );

  always #5 clk = ~clk;

  // An edge only produces a fresh issue when the station was enabled and not flushed.
  always @(posedge clk) rdy_q = rdy && rst_n && !rollback;

  always @(negedge clk) begin
    if (rdy_q && alu_bus.en) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL issue_unexpected: got rob_pos=%0d pc=%h, required no issue",
                 alu_bus.rob_pos, alu_bus.pc);
      end else begin
        mon_exp = sb.pop_front();
        if ({alu_bus.opcode, alu_bus.funct3, alu_bus.funct7, alu_bus.val1, alu_bus.val2,
             alu_bus.imm, alu_bus.rob_pos, alu_bus.pc} !==
            {mon_exp.opcode, mon_exp.funct3, mon_exp.funct7, mon_exp.val1, mon_exp.val2,
             mon_exp.imm, mon_exp.rob_pos, mon_exp.pc}) begin
          errors++;
          $display("[TB] FAIL issue_fields: got op=%h f3=%0d f7=%0d v1=%h v2=%h imm=%h rob=%0d pc=%h, required op=%h f3=%0d f7=%0d v1=%h v2=%h imm=%h rob=%0d pc=%h",
                   alu_bus.opcode, alu_bus.funct3, alu_bus.funct7, alu_bus.val1, alu_bus.val2,
                   alu_bus.imm, alu_bus.rob_pos, alu_bus.pc,
                   mon_exp.opcode, mon_exp.funct3, mon_exp.funct7, mon_exp.val1, mon_exp.val2,
                   mon_exp.imm, mon_exp.rob_pos, mon_exp.pc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dispatch(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                              input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                              input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                              input logic [31:0] imm, input logic [3:0] rob, input logic [31:0] pc);
    dec_en      = 1'b1;
    dec_opcode  = op;
    dec_funct3  = f3;
    dec_funct7  = f7;
    dec_rs1_rdy = r1;
    dec_rs1_val = v1;
    dec_rs1_rob = t1;
    dec_rs2_rdy = r2;
    dec_rs2_val = v2;
    dec_rs2_rob = t2;
    dec_imm     = imm;
    dec_rob_pos = rob;
    dec_pc      = pc;
  endtask

  task automatic push_exp(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                          input logic [3:0] rob, input logic [31:0] pc);
    exp_t e;
    e.opcode = op; e.funct3 = f3; e.funct7 = f7; e.val1 = v1; e.val2 = v2;
    e.imm = imm; e.rob_pos = rob; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic expect_en(input logic want, input string name);
    checks++;
    if (alu_bus.en !== want) begin
      errors++;
      $display("[TB] FAIL %s: alu_en got %b, required %b", name, alu_bus.en, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({alu_bus.en, rs_full, alu_bus.val1, alu_bus.val2, alu_bus.pc, alu_bus.rob_pos} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: en=%b full=%b v1=%h v2=%h pc=%h rob=%0d, required all 0",
               alu_bus.en, rs_full, alu_bus.val1, alu_bus.val2, alu_bus.pc, alu_bus.rob_pos);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_issue();
    set_dispatch(OP_CAL, 3'd0, 1'b0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 32'd0, 4'd3, 32'h100);
    push_exp(OP_CAL, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 4'd3, 32'h100);
    tick();
    dec_en = 1'b0;
    expect_en(1'b0, "basic_latency");
    tick();
    expect_en(1'b1, "basic_issue");
    tick();
    expect_en(1'b0, "basic_after");
  endtask

  task automatic test_wakeup();
    set_dispatch(OP_CAL, 3'd4, 1'b0, 1'b0, 32'd0, 4'd6, 1'b1, 32'd3, 4'd0, 32'd0, 4'd1, 32'h104);
    push_exp(OP_CAL, 3'd4, 1'b0, 32'h10, 32'd3, 32'd0, 4'd1, 32'h104);
    tick();
    dec_en = 1'b0;
    tick();
    expect_en(1'b0, "wakeup_waiting");
    alu_res_done = 1'b1; alu_res_rob_pos = 4'd6; alu_res_cal = 32'h10;
    tick();
    alu_res_done = 1'b0;
    expect_en(1'b0, "wakeup_no_same_edge_issue");
    tick();
    expect_en(1'b1, "wakeup_issue");
    tick();
    expect_en(1'b0, "wakeup_after");
  endtask

  task automatic test_same_cycle_capture();
    set_dispatch(OP_CAL, 3'd1, 1'b1, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd2, 32'd0, 4'd4, 32'h108);
    push_exp(OP_CAL, 3'd1, 1'b1, 32'd1, 32'hAB, 32'd0, 4'd4, 32'h108);
    lsb_res_done = 1'b1; lsb_res_rob_pos = 4'd2; lsb_res_val = 32'hAB;
    alu_res_done = 1'b1; alu_res_rob_pos = 4'd3; alu_res_cal = 32'hDEAD;
    tick();
    dec_en = 1'b0; lsb_res_done = 1'b0; alu_res_done = 1'b0;
    tick();
    expect_en(1'b1, "capture_issue");
    tick();
    expect_en(1'b0, "capture_after");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      set_dispatch(OP_CALI, 3'(i), 1'b0, 1'b1, 32'(i + 20), 4'd0, 1'b1, 32'd0, 4'd0,
                   32'(i + 100), 4'(i + 7), 32'(32'h200 + 4 * i));
      push_exp(OP_CALI, 3'(i), 1'b0, 32'(i + 20), 32'd0, 32'(i + 100), 4'(i + 7),
               32'(32'h200 + 4 * i));
      tick();
      expect_en(i != 0, "b2b_issue");
    end
    dec_en = 1'b0;
    tick();
    expect_en(1'b1, "b2b_last");
    tick();
    expect_en(1'b0, "b2b_after");
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      set_dispatch(OP_B, 3'(i), 1'b0, 1'b0, 32'd0, 4'd9, 1'b1, 32'(i), 4'd0,
                   32'(i * 3), 4'(i), 32'(32'h1000 + 4 * i));
      push_exp(OP_B, 3'(i), 1'b0, 32'h99, 32'(i), 32'(i * 3), 4'(i), 32'(32'h1000 + 4 * i));
      tick();
    end
    checks++;
    if (rs_full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_flag: rs_full got %b, required 1", rs_full);
    end
    set_dispatch(OP_CAL, 3'd0, 1'b0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 32'd0, 4'd15, 32'hBAD0);
    tick();
    dec_en = 1'b0;
    checks++;
    if (rs_full !== 1'b1 || alu_bus.en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_ignore: rs_full=%b alu_en=%b, required 1 and 0", rs_full, alu_bus.en);
    end
    alu_res_done = 1'b1; alu_res_rob_pos = 4'd9; alu_res_cal = 32'h99;
    tick();
    alu_res_done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      expect_en(1'b1, "full_drain_issue");
      checks++;
      if (rs_full !== 1'b0) begin
        errors++;
        $display("[TB] FAIL full_release: rs_full got %b at issue %0d, required 0", rs_full, i);
      end
    end
    tick();
    expect_en(1'b0, "full_drain_done");
  endtask

  task automatic test_rollback();
    set_dispatch(OP_CAL, 3'd0, 1'b0, 1'b0, 32'd0, 4'd12, 1'b1, 32'd1, 4'd0, 32'd0, 4'd1, 32'h400);
    tick();
    set_dispatch(OP_CAL, 3'd0, 1'b0, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd12, 32'd0, 4'd2, 32'h404);
    tick();
    set_dispatch(OP_CAL, 3'd0, 1'b0, 1'b1, 32'd8, 4'd0, 1'b1, 32'd9, 4'd0, 32'd0, 4'd3, 32'h408);
    tick();
    dec_en = 1'b0;
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    checks++;
    if (alu_bus.en !== 1'b0 || rs_full !== 1'b0 || alu_bus.val1 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL rollback_clear: en=%b full=%b val1=%h, required 0 0 0",
               alu_bus.en, rs_full, alu_bus.val1);
    end
    alu_res_done = 1'b1; alu_res_rob_pos = 4'd12; alu_res_cal = 32'h5;
    tick();
    alu_res_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_en(1'b0, "rollback_no_issue");
    end
  endtask

  task automatic test_rdy_freeze();
    set_dispatch(OP_CAL, 3'd2, 1'b0, 1'b0, 32'd0, 4'd4, 1'b1, 32'd2, 4'd0, 32'd0, 4'd5, 32'h300);
    tick();
    set_dispatch(OP_CAL, 3'd7, 1'b1, 1'b1, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0, 32'd0, 4'd6, 32'h304);
    tick();
    rdy = 1'b0;
    set_dispatch(OP_CAL, 3'd0, 1'b0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 32'd0, 4'd8, 32'hBAD4);
    alu_res_done = 1'b1; alu_res_rob_pos = 4'd4; alu_res_cal = 32'h44;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_en(1'b0, "freeze_hold");
    end
    rdy = 1'b1; dec_en = 1'b0; alu_res_done = 1'b0;
    push_exp(OP_CAL, 3'd7, 1'b1, 32'h11, 32'h22, 32'd0, 4'd6, 32'h304);
    tick();
    expect_en(1'b1, "freeze_resume_issue");
    rdy = 1'b0;
    tick();
    checks++;
    if (alu_bus.en !== 1'b1 || alu_bus.rob_pos !== 4'd6) begin
      errors++;
      $display("[TB] FAIL freeze_output_hold: en=%b rob=%0d, required 1 and 6", alu_bus.en, alu_bus.rob_pos);
    end
    rdy = 1'b1;
    tick();
    expect_en(1'b0, "freeze_lost_broadcast");
    alu_res_done = 1'b1; alu_res_rob_pos = 4'd4; alu_res_cal = 32'h44;
    push_exp(OP_CAL, 3'd2, 1'b0, 32'h44, 32'd2, 32'd0, 4'd5, 32'h300);
    tick();
    alu_res_done = 1'b0;
    expect_en(1'b0, "freeze_wake");
    tick();
    expect_en(1'b1, "freeze_late_issue");
    tick();
    expect_en(1'b0, "freeze_after");
  endtask

  initial begin
    rdy = 1'b1; rollback = 1'b0; dec_en = 1'b0;
    dec_opcode = '0; dec_funct3 = '0; dec_funct7 = 1'b0;
    dec_rs1_rdy = 1'b1; dec_rs1_val = '0; dec_rs1_rob = '0;
    dec_rs2_rdy = 1'b1; dec_rs2_val = '0; dec_rs2_rob = '0;
    dec_imm = '0; dec_rob_pos = '0; dec_pc = '0;
    alu_res_done = 1'b0; alu_res_rob_pos = '0; alu_res_cal = '0;
    lsb_res_done = 1'b0; lsb_res_rob_pos = '0; lsb_res_val = '0;
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_same_cycle_capture();
    test_back_to_back();
    test_full();
    test_rollback();
    test_rdy_freeze();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d ops never issued, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
